picorv32_ctrl_fsm: RTL and testbench
====================================

Name: picorv32_ctrl_fsm

Overview:
Parametrised next-generation main control FSM for the modularized picorv32 core. It sequences fetch, register load, execute, shift, load/store and trap states from decoder class flags. Over the existing controller it adds:
- XLEN 32/64.
- An explicit wait-for-IRQ state.
- A memory-timeout watchdog.
- A latched trap cause.
- A fault-to-IRQ request pulse.
- A retired-instruction counter.

It sits between the instruction decoder, memory interface and datapath.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ENABLE_REGS_DUALPORT, 1, 1: LD_RS1 dispatches directly; 0: via LD_RS2.
- ENABLE_IRQ, 1, allows faults to become IRQ requests instead of TRAP.
- CATCH_MISALIGN, 1, enables alignment checks.
- CATCH_ILLINSN, 1, enables illegal-instruction trapping.
- WITH_PCPI, 1, instr_trap waits for pcpi_int_ready/pcpi_timeout.
- TWO_CYCLE_ALU, 0, EXEC holds while alu_wait.
- MEM_TIMEOUT, 0, cycles without mem_done before a bus fault; 0 disables the watchdog.
- CNT_WIDTH, 32, instret width (1..64).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- decoder_trigger  in  1  decoded instruction valid
- instr_jal  in  1  JAL; completes in FETCH
- instr_waitirq  in  1  waitirq instruction
- instr_trap  in  1  unknown/PCPI instruction
- is_single_cycle  in  1  counters/getq/setq/retirq/maskirq/timer
- is_lui_auipc_jal  in  1  decoder class flag
- is_jalr_addi_imm  in  1  decoder class flag
- is_load  in  1  decoder class flag
- is_store  in  1  decoder class flag
- is_shift_imm  in  1  decoder class flag
- is_shift_reg  in  1  decoder class flag
- is_branch  in  1  decoder class flag
- pcpi_int_ready  in  1  PCPI handshake
- pcpi_timeout  in  1  PCPI handshake
- alu_wait  in  1  ALU busy
- mem_do_rinst  in  1  memory request, instruction read
- mem_do_rdata  in  1  memory request, data read
- mem_do_wdata  in  1  memory request, data write
- mem_done  in  1  memory transfer complete
- mem_wordsize  in  2  0=word, 1=half, 2=byte, 3=dword (XLEN=64 only)
- reg_op1  in  XLEN  data address
- reg_pc  in  XLEN  program counter
- reg_sh  in  $clog2(XLEN)  remaining shift amount
- irq_unmasked_pending  in  1  |(pending & ~mask)
- irq_active  in  1  IRQ handler running
- irq_mask_sbreak  in  1  mask bit for sbreak IRQ
- irq_mask_buserror  in  1  mask bit for bus-error IRQ
- cpu_state  out  9  one-hot: [8]WAITIRQ [7]EXEC [6]FETCH [5]LD_RS1 [4]LD_RS2 [3]LDMEM [2]SHIFT [1]STMEM [0]TRAP
- trap_cause  out  3  0 none, 1 illegal, 2 misaligned data, 3 misaligned fetch, 4 mem timeout, 5 PCPI timeout
- fault_irq_req  out  1  one-cycle pulse: a fault was redirected to IRQ
- instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async): cpu_state=FETCH, trap_cause=0, fault_irq_req=0, instret=0, watchdog=0.
- "Redirectable" means ENABLE_IRQ && mask bit clear && !irq_active.
- Fault action: if redirectable, go to FETCH and pulse fault_irq_req; otherwise go to TRAP. In both cases latch trap_cause.
- FETCH, on decoder_trigger:
  - ENABLE_IRQ && irq_unmasked_pending && !irq_active: stay in FETCH.
  - ENABLE_IRQ && instr_waitirq: go to WAITIRQ.
  - instr_jal: stay in FETCH and retire.
  - Otherwise: go to LD_RS1.
- WAITIRQ: return to FETCH when irq_unmasked_pending; retire on exit.
- LD_RS1 priority (first match wins):
  1. instr_trap:
     - WITH_PCPI && dualport: wait for ready (go to FETCH, retire) or timeout (fault, cause 5, mask=sbreak).
     - WITH_PCPI && !dualport: go to LD_RS2.
     - !WITH_PCPI && CATCH_ILLINSN: fault, cause 1.
  2. is_single_cycle: FETCH, retire.
  3. is_lui_auipc_jal or is_jalr_addi_imm: EXEC.
  4. is_load: LDMEM.
  5. is_shift_imm: SHIFT.
  6. Otherwise: dualport: store→STMEM, shift_reg→SHIFT, else→EXEC; !dualport: LD_RS2.
- LD_RS2: same PCPI handling as LD_RS1, then store / shift_reg / EXEC.
- EXEC:
  - Hold while TWO_CYCLE_ALU && alu_wait.
  - Branch: hold until mem_done.
  - Then go to FETCH and retire.
- SHIFT: go to FETCH and retire when reg_sh==0.
- LDMEM/STMEM: go to FETCH and retire on mem_done.
- TRAP: absorbing until reset; instret frozen.
- Retire: instret += 1 on the exiting cycle; wraps modulo 2^CNT_WIDTH.
- Watchdog:
  - Counts cycles while any mem_do_* is set and mem_done is low; clears on mem_done or when no request is pending.
  - When the count reaches MEM_TIMEOUT: fault, cause 4, mask=buserror.
- Misalign check (CATCH_MISALIGN):
  - Data (rdata|wdata): word needs reg_op1[1:0]==0; half needs [0]==0; dword needs [2:0]==0 → cause 2.
  - Fetch (rinst): reg_pc[1:0]!=0 → cause 3.
  - mask=buserror.
- Priority when several events hit in one cycle: fetch-misalign > data-misalign > timeout > state-case result; the last-evaluated override wins.
- trap_cause holds its value until the next fault or reset.
- fault_irq_req is never asserted in the same cycle as a TRAP entry.

Decomposition:
- Shared package picorv32_ctrl_pkg holds the state one-hot constants, trap_cause codes and mem_wordsize codes.
- Sub-module picorv32_mem_watchdog: counter, compare and timeout pulse.

Test Plan:
- ADDI path: decoder_trigger + is_jalr_addi_imm → FETCH→LD_RS1→EXEC→FETCH; instret 0→1.
- Load with reg_op1=0x1002, word, irq_mask_buserror=1 → TRAP next cycle, trap_cause=2, fault_irq_req=0.
- Same load with mask=0, irq_active=0 → FETCH, fault_irq_req high 1 cycle, trap_cause=2.
- MEM_TIMEOUT=4, STMEM, mem_do_wdata held, mem_done never → TRAP on 4th cycle, cause=4.
- waitirq: FETCH→WAITIRQ; assert irq_unmasked_pending after 10 cycles → FETCH next cycle; instret +1.
- CNT_WIDTH=4, instret=15, retire → instret=0; assert reset mid-EXEC → FETCH asynchronously, all outputs 0.

Source files
------------

// File: rtl/picorv32_ctrl_pkg.sv
// picorv32_ctrl_pkg: shared state encodings, trap causes and memory word-size codes for the control FSM
package picorv32_ctrl_pkg;
  typedef enum logic [8:0] {
    S_TRAP    = 9'b0_0000_0001,
    S_STMEM   = 9'b0_0000_0010,
    S_SHIFT   = 9'b0_0000_0100,
    S_LDMEM   = 9'b0_0000_1000,
    S_LD_RS2  = 9'b0_0001_0000,
    S_LD_RS1  = 9'b0_0010_0000,
    S_FETCH   = 9'b0_0100_0000,
    S_EXEC    = 9'b0_1000_0000,
    S_WAITIRQ = 9'b1_0000_0000
  } state_e;
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_ILLEGAL,
    CAUSE_MISALIGN_DATA,
    CAUSE_MISALIGN_FETCH,
    CAUSE_MEM_TIMEOUT,
    CAUSE_PCPI_TIMEOUT
  } cause_e;
  localparam logic [1:0] WS_WORD  = 2'd0;
  localparam logic [1:0] WS_HALF  = 2'd1;
  localparam logic [1:0] WS_BYTE  = 2'd2;
  localparam logic [1:0] WS_DWORD = 2'd3;
  function automatic logic [2:0] align_mask(input logic [1:0] ws);
    return ws == WS_DWORD ? 3'b111 : ws == WS_HALF ? 3'b001 : ws == WS_BYTE ? 3'b000 : 3'b011;
  endfunction
endpackage

// File: rtl/picorv32_mem_watchdog.sv
// picorv32_mem_watchdog: counts stalled memory-request cycles and pulses timeout after MEM_TIMEOUT of them
module picorv32_mem_watchdog #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic mem_done,
  output logic timeout
);
  localparam int CW  = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LIM = MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy;
  always_comb begin
    busy = req && !mem_done;
    timeout = (MEM_TIMEOUT != 0) && busy && cnt_q == CW'(LIM);
    cnt_d = ((MEM_TIMEOUT != 0) && busy && !timeout) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/picorv32_ctrl_fsm.sv
// picorv32_ctrl_fsm: main control FSM sequencing fetch, operand load, execute, shift, memory and trap states
module picorv32_ctrl_fsm
  import picorv32_ctrl_pkg::*;
#(
  parameter int XLEN                 = 32,
  parameter bit ENABLE_REGS_DUALPORT = 1'b1,
  parameter bit ENABLE_IRQ           = 1'b1,
  parameter bit CATCH_MISALIGN       = 1'b1,
  parameter bit CATCH_ILLINSN        = 1'b1,
  parameter bit WITH_PCPI            = 1'b1,
  parameter bit TWO_CYCLE_ALU        = 1'b0,
  parameter int MEM_TIMEOUT          = 0,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    decoder_trigger,
  input  logic                    instr_jal,
  input  logic                    instr_waitirq,
  input  logic                    instr_trap,
  input  logic                    is_single_cycle,
  input  logic                    is_lui_auipc_jal,
  input  logic                    is_jalr_addi_imm,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic                    is_shift_imm,
  input  logic                    is_shift_reg,
  input  logic                    is_branch,
  input  logic                    pcpi_int_ready,
  input  logic                    pcpi_timeout,
  input  logic                    alu_wait,
  input  logic                    mem_do_rinst,
  input  logic                    mem_do_rdata,
  input  logic                    mem_do_wdata,
  input  logic                    mem_done,
  input  logic [1:0]              mem_wordsize,
  input  logic [XLEN-1:0]         reg_op1,
  input  logic [XLEN-1:0]         reg_pc,
  input  logic [$clog2(XLEN)-1:0] reg_sh,
  input  logic                    irq_unmasked_pending,
  input  logic                    irq_active,
  input  logic                    irq_mask_sbreak,
  input  logic                    irq_mask_buserror,
  output logic [8:0]              cpu_state,
  output logic [2:0]              trap_cause,
  output logic                    fault_irq_req,
  output logic [CNT_WIDTH-1:0]    instret
);
  state_e state_q, state_d;
  cause_e fault;
  logic [2:0] cause_q, cause_d;
  logic fir_q, fir_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic retire, mem_timeout, data_mis, fetch_mis, mask_bit, redirect, rs1;

  picorv32_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (reset),
    .req     (mem_do_rinst | mem_do_rdata | mem_do_wdata),
    .mem_done(mem_done),
    .timeout (mem_timeout)
  );

  assign rs1       = state_q == S_LD_RS1;
  assign data_mis  = CATCH_MISALIGN && (mem_do_rdata || mem_do_wdata) && |(reg_op1 & XLEN'(align_mask(mem_wordsize)));
  assign fetch_mis = CATCH_MISALIGN && mem_do_rinst && |(reg_pc & XLEN'(3));

  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    fault = CAUSE_NONE;
    case (state_q)
      S_FETCH:
        if (decoder_trigger) begin
          if (ENABLE_IRQ && irq_unmasked_pending && !irq_active) state_d = S_FETCH;
          else if (ENABLE_IRQ && instr_waitirq) state_d = S_WAITIRQ;
          else if (instr_jal) retire = 1'b1;
          else state_d = S_LD_RS1;
        end
      S_WAITIRQ:
        if (irq_unmasked_pending) begin
          state_d = S_FETCH;
          retire = 1'b1;
        end
      S_LD_RS1, S_LD_RS2:
        if (instr_trap && (WITH_PCPI || CATCH_ILLINSN)) begin
          if (!WITH_PCPI) fault = CAUSE_ILLEGAL;
          else if (rs1 && !ENABLE_REGS_DUALPORT) state_d = S_LD_RS2;
          else if (pcpi_int_ready) begin
            state_d = S_FETCH;
            retire = 1'b1;
          end else if (pcpi_timeout) fault = CAUSE_PCPI_TIMEOUT;
        end else if (rs1 && is_single_cycle) begin
          state_d = S_FETCH;
          retire = 1'b1;
        end else if (rs1 && (is_lui_auipc_jal || is_jalr_addi_imm)) state_d = S_EXEC;
        else if (rs1 && is_load) state_d = S_LDMEM;
        else if (rs1 && is_shift_imm) state_d = S_SHIFT;
        else if (rs1 && !ENABLE_REGS_DUALPORT) state_d = S_LD_RS2;
        else if (is_store) state_d = S_STMEM;
        else if (is_shift_reg) state_d = S_SHIFT;
        else state_d = S_EXEC;
      S_EXEC:
        if (!(TWO_CYCLE_ALU && alu_wait) && !(is_branch && !mem_done)) begin
          state_d = S_FETCH;
          retire = 1'b1;
        end
      S_SHIFT:
        if (reg_sh == '0) begin
          state_d = S_FETCH;
          retire = 1'b1;
        end
      S_LDMEM, S_STMEM:
        if (mem_done) begin
          state_d = S_FETCH;
          retire = 1'b1;
        end
      default: ;
    endcase
    // later overrides take priority: fetch misalign beats data misalign beats timeout
    if (state_q != S_TRAP) begin
      if (mem_timeout) fault = CAUSE_MEM_TIMEOUT;
      if (data_mis) fault = CAUSE_MISALIGN_DATA;
      if (fetch_mis) fault = CAUSE_MISALIGN_FETCH;
    end
    mask_bit = (fault == CAUSE_ILLEGAL || fault == CAUSE_PCPI_TIMEOUT) ? irq_mask_sbreak : irq_mask_buserror;
    redirect = ENABLE_IRQ && !mask_bit && !irq_active;
    fir_d = (fault != CAUSE_NONE) && redirect;
    cause_d = (fault != CAUSE_NONE) ? fault : cause_q;
    if (fault != CAUSE_NONE) begin
      retire = 1'b0;
      if (redirect) state_d = S_FETCH;
      else state_d = S_TRAP;
    end
    instret_d = instret_q + CNT_WIDTH'(retire);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_FETCH;
      cause_q   <= '0;
      fir_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      fir_q     <= fir_d;
      instret_q <= instret_d;
    end

  assign cpu_state     = state_q;
  assign trap_cause    = cause_q;
  assign fault_irq_req = fir_q;
  assign instret       = instret_q;
endmodule

// File: tb/tb_picorv32_ctrl_fsm.sv
// tb_picorv32_ctrl_fsm: directed and random stimulus scored against an instruction-rule reference model
module tb_picorv32_ctrl_fsm;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int TRAP = 0, STMEM = 1, SHIFT = 2, LDMEM = 3, LD_RS2 = 4, LD_RS1 = 5, FETCH = 6, EXEC = 7, WAITIRQ = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic decoder_trigger, instr_jal, instr_waitirq, instr_trap, is_single_cycle, is_lui_auipc_jal;
  logic is_jalr_addi_imm, is_load, is_store, is_shift_imm, is_shift_reg, is_branch;
  logic pcpi_int_ready, pcpi_timeout, alu_wait, mem_do_rinst, mem_do_rdata, mem_do_wdata, mem_done;
  logic irq_unmasked_pending, irq_active, irq_mask_sbreak, irq_mask_buserror;
  logic [1:0] mem_wordsize;
  logic [31:0] reg_op1, reg_pc;
  logic [4:0] reg_sh;
  logic [8:0] cpu_state;
  logic [2:0] trap_cause;
  logic fault_irq_req;
  logic [CW-1:0] instret;

  typedef struct packed {
    logic [8:0]    st;
    logic [2:0]    cause;
    logic          fir;
    logic [CW-1:0] ir;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int m_state, m_cause, m_instret, m_wd;
  bit m_fir;

  always #5 clk = ~clk;

  picorv32_ctrl_fsm #(
    .XLEN(32), .ENABLE_REGS_DUALPORT(1'b1), .ENABLE_IRQ(1'b1), .CATCH_MISALIGN(1'b1),
    .CATCH_ILLINSN(1'b1), .WITH_PCPI(1'b1), .TWO_CYCLE_ALU(1'b1), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .decoder_trigger(decoder_trigger), .instr_jal(instr_jal),
    .instr_waitirq(instr_waitirq), .instr_trap(instr_trap), .is_single_cycle(is_single_cycle),
    .is_lui_auipc_jal(is_lui_auipc_jal), .is_jalr_addi_imm(is_jalr_addi_imm), .is_load(is_load),
    .is_store(is_store), .is_shift_imm(is_shift_imm), .is_shift_reg(is_shift_reg), .is_branch(is_branch),
    .pcpi_int_ready(pcpi_int_ready), .pcpi_timeout(pcpi_timeout), .alu_wait(alu_wait),
    .mem_do_rinst(mem_do_rinst), .mem_do_rdata(mem_do_rdata), .mem_do_wdata(mem_do_wdata),
    .mem_done(mem_done), .mem_wordsize(mem_wordsize), .reg_op1(reg_op1), .reg_pc(reg_pc), .reg_sh(reg_sh),
    .irq_unmasked_pending(irq_unmasked_pending), .irq_active(irq_active),
    .irq_mask_sbreak(irq_mask_sbreak), .irq_mask_buserror(irq_mask_buserror),
    .cpu_state(cpu_state), .trap_cause(trap_cause), .fault_irq_req(fault_irq_req), .instret(instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of the architectural rules: transition, then faults by rising priority
  task automatic model_step();
    int nxt, cause, size;
    bit ret, busy, tmo, irq_ok;
    nxt = m_state;
    ret = 0;
    cause = 0;
    busy = (mem_do_rinst || mem_do_rdata || mem_do_wdata) && !mem_done;
    m_wd = busy ? m_wd + 1 : 0;
    tmo = busy && m_wd == TMO;
    if (tmo) m_wd = 0;
    case (m_state)
      FETCH:
        if (decoder_trigger) begin
          if (irq_unmasked_pending && !irq_active) nxt = FETCH;
          else if (instr_waitirq) nxt = WAITIRQ;
          else if (instr_jal) ret = 1;
          else nxt = LD_RS1;
        end
      WAITIRQ: if (irq_unmasked_pending) begin nxt = FETCH; ret = 1; end
      LD_RS1, LD_RS2:
        if (instr_trap) begin
          if (pcpi_int_ready) begin nxt = FETCH; ret = 1; end
          else if (pcpi_timeout) cause = 5;
        end
        else if (m_state == LD_RS1 && is_single_cycle) begin nxt = FETCH; ret = 1; end
        else if (m_state == LD_RS1 && (is_lui_auipc_jal || is_jalr_addi_imm)) nxt = EXEC;
        else if (m_state == LD_RS1 && is_load) nxt = LDMEM;
        else if (m_state == LD_RS1 && is_shift_imm) nxt = SHIFT;
        else if (is_store) nxt = STMEM;
        else if (is_shift_reg) nxt = SHIFT;
        else nxt = EXEC;
      EXEC: if (!alu_wait && !(is_branch && !mem_done)) begin nxt = FETCH; ret = 1; end
      SHIFT: if (reg_sh == 0) begin nxt = FETCH; ret = 1; end
      LDMEM, STMEM: if (mem_done) begin nxt = FETCH; ret = 1; end
      default: ;
    endcase
    size = mem_wordsize == 0 ? 4 : mem_wordsize == 1 ? 2 : mem_wordsize == 2 ? 1 : 8;
    if (m_state != TRAP) begin
      if (tmo) cause = 4;
      if ((mem_do_rdata || mem_do_wdata) && (reg_op1 % size) != 0) cause = 2;
      if (mem_do_rinst && (reg_pc % 4) != 0) cause = 3;
    end
    m_fir = 0;
    if (cause != 0) begin
      irq_ok = !((cause == 5 || cause == 1) ? irq_mask_sbreak : irq_mask_buserror) && !irq_active;
      m_cause = cause;
      ret = 0;
      nxt = irq_ok ? FETCH : TRAP;
      m_fir = irq_ok;
    end
    m_state = nxt;
    m_instret = (m_instret + int'(ret)) % (1 << CW);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.st = 9'b1 << m_state;
    e.cause = 3'(m_cause);
    e.fir = m_fir;
    e.ir = CW'(m_instret);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(cpu_state), 32'h040);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_fir", 32'(fault_irq_req), 0);
    chk("rst_instret", 32'(instret), 0);
    m_state = FETCH; m_cause = 0; m_fir = 0; m_instret = 0; m_wd = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    {decoder_trigger, instr_jal, instr_waitirq, instr_trap, is_single_cycle, is_lui_auipc_jal} = '0;
    {is_jalr_addi_imm, is_load, is_store, is_shift_imm, is_shift_reg, is_branch} = '0;
    {pcpi_int_ready, pcpi_timeout, alu_wait, mem_do_rinst, mem_do_rdata, mem_do_wdata, mem_done} = '0;
    {irq_unmasked_pending, irq_active, irq_mask_sbreak, irq_mask_buserror} = '0;
    mem_wordsize = 2'd0; reg_op1 = '0; reg_pc = '0; reg_sh = '0;
  endtask

  task automatic rand_inputs();
    decoder_trigger = $urandom_range(1);
    instr_jal = $urandom_range(4) == 0;
    instr_waitirq = $urandom_range(6) == 0;
    instr_trap = $urandom_range(5) == 0;
    is_single_cycle = $urandom_range(5) == 0;
    is_lui_auipc_jal = $urandom_range(6) == 0;
    is_jalr_addi_imm = $urandom_range(5) == 0;
    is_load = $urandom_range(4) == 0;
    is_store = $urandom_range(4) == 0;
    is_shift_imm = $urandom_range(5) == 0;
    is_shift_reg = $urandom_range(5) == 0;
    is_branch = $urandom_range(3) == 0;
    pcpi_int_ready = $urandom_range(3) == 0;
    pcpi_timeout = $urandom_range(6) == 0;
    alu_wait = $urandom_range(3) == 0;
    mem_do_rinst = $urandom_range(6) == 0;
    mem_do_rdata = $urandom_range(5) == 0;
    mem_do_wdata = $urandom_range(5) == 0;
    mem_done = $urandom_range(4) < 2;
    mem_wordsize = 2'($urandom_range(2));
    reg_op1 = $urandom();
    if ($urandom_range(3) != 0) reg_op1[2:0] = 3'd0;
    reg_pc = $urandom();
    if ($urandom_range(19) != 0) reg_pc[1:0] = 2'd0;
    reg_sh = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
    irq_unmasked_pending = $urandom_range(6) == 0;
    irq_active = $urandom_range(2) == 0;
    irq_mask_sbreak = $urandom_range(1);
    irq_mask_buserror = $urandom_range(1);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset && sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      if ({cpu_state, trap_cause, fault_irq_req, instret} !== e) begin
        fails++;
        $display("FAIL sb @%0t: state %h cause %0d fir %0b instret %0d, expected state %h cause %0d fir %0b instret %0d",
                 $time, cpu_state, trap_cause, fault_irq_req, instret, e.st, e.cause, e.fir, e.ir);
      end
    end
  end

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    // ADDI path
    decoder_trigger = 1; is_jalr_addi_imm = 1; step();
    chk("addi_rs1", 32'(cpu_state), 32'h020);
    decoder_trigger = 0; step();
    chk("addi_exec", 32'(cpu_state), 32'h080);
    step();
    chk("addi_fetch", 32'(cpu_state), 32'h040);
    chk("addi_instret", 32'(instret), 1);
    // misaligned load with bus-error IRQ masked traps
    idle(); decoder_trigger = 1; is_load = 1; step();
    decoder_trigger = 0; step();
    chk("load_ldmem", 32'(cpu_state), 32'h008);
    mem_do_rdata = 1; reg_op1 = 32'h1002; irq_mask_buserror = 1; step();
    chk("mis_trap_state", 32'(cpu_state), 32'h001);
    chk("mis_trap_cause", 32'(trap_cause), 2);
    chk("mis_trap_fir", 32'(fault_irq_req), 0);
    idle(); step(); step();
    chk("trap_absorb", 32'(cpu_state), 32'h001);
    chk("trap_instret", 32'(instret), 1);
    do_reset();
    // same fault unmasked redirects to an IRQ request
    decoder_trigger = 1; is_load = 1; step();
    decoder_trigger = 0; step();
    mem_do_rdata = 1; reg_op1 = 32'h1002; step();
    chk("redir_state", 32'(cpu_state), 32'h040);
    chk("redir_fir", 32'(fault_irq_req), 1);
    chk("redir_cause", 32'(trap_cause), 2);
    idle(); step();
    chk("redir_fir_pulse", 32'(fault_irq_req), 0);
    chk("redir_cause_hold", 32'(trap_cause), 2);
    // store that never completes hits the watchdog
    decoder_trigger = 1; is_store = 1; step();
    decoder_trigger = 0; step();
    chk("st_stmem", 32'(cpu_state), 32'h002);
    mem_do_wdata = 1; irq_mask_buserror = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("tmo_wait", 32'(cpu_state), 32'h002);
    end
    step();
    chk("tmo_trap", 32'(cpu_state), 32'h001);
    chk("tmo_cause", 32'(trap_cause), 4);
    idle(); do_reset();
    // wait-for-IRQ
    decoder_trigger = 1; instr_waitirq = 1; step();
    chk("wfi_enter", 32'(cpu_state), 32'h100);
    idle(); repeat (10) step();
    chk("wfi_hold", 32'(cpu_state), 32'h100);
    irq_unmasked_pending = 1; step();
    chk("wfi_exit", 32'(cpu_state), 32'h040);
    chk("wfi_retire", 32'(instret), 1);
    // counter wrap
    idle(); decoder_trigger = 1; instr_jal = 1;
    repeat (14) step();
    chk("instret_max", 32'(instret), 15);
    step();
    chk("instret_wrap", 32'(instret), 0);
    step();
    // fetch misalign redirected, then async reset while EXEC holds
    idle(); mem_do_rinst = 1; reg_pc = 32'h2; step();
    chk("fmis_cause", 32'(trap_cause), 3);
    chk("fmis_fir", 32'(fault_irq_req), 1);
    idle(); decoder_trigger = 1; is_jalr_addi_imm = 1; step();
    decoder_trigger = 0; alu_wait = 1; step(); step();
    chk("exec_hold", 32'(cpu_state), 32'h080);
    do_reset();
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ((m_state == TRAP && $urandom_range(3) == 0) || $urandom_range(499) == 0) do_reset();
      else begin
        rand_inputs();
        step();
      end
    end
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
